// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop rx synchronizer, 16x-oversampled start/data/stop FSM, registered done pulse.
// Optional even-parity stage and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
`ifdef UART_RX_PARITY_EN
  output logic            parity_err,
`endif
  output logic            busy
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   s, s_nxt;
  logic [2:0]      n, n_nxt;
  logic [DBIT-1:0] b, b_nxt;
  logic [DBIT-1:0] dout_nxt;
  logic            frame_err_nxt;
  logic            done_nxt;
  logic            rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
  logic            p_bit, p_bit_nxt;
  logic            parity_err_nxt;
`endif

  // Synchronizer resets to the idle-high line level so release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p_bit        <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      s            <= s_nxt;
      n            <= n_nxt;
      b            <= b_nxt;
      dout         <= dout_nxt;
      frame_err    <= frame_err_nxt;
      rx_done_tick <= done_nxt;
`ifdef UART_RX_PARITY_EN
      p_bit        <= p_bit_nxt;
      parity_err   <= parity_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    s_nxt         = s;
    n_nxt         = n;
    b_nxt         = b;
    dout_nxt      = dout;
    frame_err_nxt = frame_err;
    done_nxt      = 1'b0;
`ifdef UART_RX_PARITY_EN
    p_bit_nxt      = p_bit;
    parity_err_nxt = parity_err;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            // Line back high at mid start bit: treat as a glitch.
            if (!rx_s) begin
              state_nxt = DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            b_nxt = {rx_s, b[DBIT-1:1]};
            s_nxt = '0;
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              n_nxt = n + 3'd1;
            end
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == S_BIT) begin
            p_bit_nxt = rx_s;
            s_nxt     = '0;
            state_nxt = STOP;
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            state_nxt     = IDLE;
            dout_nxt      = b;
            frame_err_nxt = ~rx_s;
            done_nxt      = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_nxt = (^b) ^ p_bit;
`endif
          end else begin
            s_nxt = s + SW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have a parameter DBIT, default 8, giving data bits per frame; legal range 5..8.
REQ-002 The block SHALL have a parameter SB_TICK, default 16, giving stop-bit length in oversample ticks; legal values 16, 24, 32.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_tick  input  1  16x-baud oversample strobe, one clk cycle wide (timer done pulse).
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 dout  output  DBIT  last received data word, LSB received first.
REQ-008 rx_done_tick  output  1  one-cycle pulse when a frame completes.
REQ-009 frame_err  output  1  stop bit of last frame sampled low.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP (plus PARITY when UART_RX_PARITY_EN is defined).
REQ-013 Tick counter s (4 bits, 5 bits if SB_TICK>16) and bit counter n (3 bits) SHALL advance only on cycles with s_tick=1.
REQ-014 IDLE: on rx_s=0 (no s_tick needed), go to START with s=0.
REQ-015 START: on s_tick with s=7, if rx_s=0 go to DATA with s=0, n=0; if rx_s=1 return to IDLE (glitch reject, no pulse); otherwise increment s on s_tick.
REQ-016 DATA: on s_tick with s=15, shift register b <= {rx_s, b[DBIT-1:1]}, s=0; if n=DBIT-1 go to STOP (or PARITY), else n=n+1.
REQ-017 STOP: on s_tick with s=SB_TICK-1, go to IDLE, load dout<=b, frame_err<=~rx_s, and assert rx_done_tick.
REQ-018 rx_done_tick SHALL be registered, high for exactly one clk cycle, starting at the clock edge of REQ-017.
REQ-019 dout and frame_err SHALL hold their value until the next completed frame; a glitch-rejected start leaves them unchanged.
REQ-020 s_tick while in IDLE SHALL have no effect; rx activity during STOP other than the sample SHALL be ignored.
REQ-021 A new start bit SHALL be detectable in the cycle after the return to IDLE (back-to-back frames).

Reset
REQ-022 On rst_n=0: state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick and no update of dout after release.

Configuration
REQ-024 Macro UART_RX_PARITY_EN SHALL, when defined, add state PARITY between DATA and STOP and output parity_err (1 bit, reset 0).
REQ-025 With UART_RX_PARITY_EN: PARITY samples rx_s on s_tick with s=15, then goes to STOP with s=0; parity_err <= (^b) ^ p_bit (even parity), loaded at the rx_done_tick edge.
REQ-026 Without UART_RX_PARITY_EN: no PARITY state, no parity_err port, frame = start + DBIT + stop.

Verification
REQ-027 s_tick every cycle, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one rx_done_tick, dout=0xA5, frame_err=0, busy low afterwards.
REQ-028 rx low for 4 ticks then high -> FSM returns to IDLE at tick 7, no rx_done_tick, dout unchanged.
REQ-029 frame 0x3C with stop bit 0 -> rx_done_tick, dout=0x3C, frame_err=1; next clean frame 0x81 -> frame_err=0.
REQ-030 rst_n pulsed low during bit 4 of a frame -> all outputs 0, no rx_done_tick; next full frame 0x55 received correctly.
REQ-031 back-to-back frames 0x01, 0xFE with no idle gap -> two rx_done_tick pulses, dout 0x01 then 0xFE.
REQ-032 UART_RX_PARITY_EN defined, frame 0x07 with parity bit 0 -> parity_err=1; with parity bit 1 -> parity_err=0.
